mem_access_unit: RTL

Multicycle memory port that sits directly downstream of the MIPS multicycle controller. It consumes the controller's `lorD`, `MemWrite` and `IRWrite` decisions and turns each access into a req/ack transaction on a wait-state-capable external memory bus. Read data is captured into the instruction register (IR) or the memory data register (MDR). While a transaction is outstanding the unit asserts `Stall`, which the controller uses to hold its current state.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mem_access_unit_wait_timer.sv | 62 ++++++
 rtl/mem_access_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS multicycle core: the common data width,
// the memory access unit state encoding and the word-alignment helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_pkg;

  // Data / address width shared by controller, datapath and memory port
  localparam int DW = 32;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  // Memory access unit states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } mau_state_t;

  // True when the two low address bits describe a word-aligned address
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return ((addr_lsbs & WORD_ALIGN_MASK) == 2'b00);
  endfunction

endpackage : mips_pkg

// File: rtl/mem_access_unit_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Loadable saturating up-counter used to bound the number of wait states of
// a bus transaction. Priority: clr > load > en. The counter sticks at its
// maximum value instead of wrapping. tc is high while the count equals
// TIMEOUT-1; with TIMEOUT = 0 tc never asserts.
//
// Ports:
//   clk      in  1   rising-edge clock
//   rst_n    in  1   asynchronous active-low reset (count -> 0)
//   clr      in  1   synchronous clear to 0
//   load     in  1   synchronous load of load_val
//   load_val in  CW  value loaded when load=1
//   en       in  1   count enable
//   tc       out 1   terminal count (count == TIMEOUT-1)
// ---------------------------------------------------------------------------
module wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          tc
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TC_VAL  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic          TC_EN   = (TIMEOUT > 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear, load, or saturating increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != CNT_MAX)) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = TC_EN & (count_q == TC_VAL);

endmodule : wait_timer

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Multicycle memory port for the MIPS multicycle core. A one-cycle Access
// strobe from the controller is turned into a req/ack transaction on a
// wait-state-capable memory bus. Load data lands in IR (IRWrite=1) or MDR
// (IRWrite=0). Stall holds the controller while a transaction is pending.
// Misaligned addresses and bus timeouts are reported with a one-cycle Err.
//
// Ports:
//   Clk        in  1   rising-edge clock
//   Rst_n      in  1   asynchronous active-low reset
//   Access     in  1   start strobe (accepted only in IDLE)
//   lorD       in  1   address select: 0 = PC, 1 = ALUOut
//   MemWrite   in  1   1 = store, 0 = load
//   IRWrite    in  1   load target: 1 = IR, 0 = MDR
//   PC         in  DW  instruction address
//   ALUOut     in  DW  data address
//   WriteData  in  DW  store data
//   mem_req    out 1   bus request (registered)
//   mem_we     out 1   bus write enable (registered)
//   mem_addr   out DW  bus address (registered)
//   mem_wdata  out DW  bus write data (registered)
//   mem_rdata  in  DW  bus read data, valid with mem_ack
//   mem_ack    in  1   single-cycle completion
//   Instr      out DW  IR contents
//   MemData    out DW  MDR contents
//   Stall      out 1   transaction in progress (combinational)
//   Done       out 1   one-cycle completion pulse (registered)
//   Err        out 1   one-cycle misalign/timeout pulse (registered)
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DW      = mips_pkg::DW,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Access,
  input  logic          lorD,
  input  logic          MemWrite,
  input  logic          IRWrite,
  input  logic [DW-1:0] PC,
  input  logic [DW-1:0] ALUOut,
  input  logic [DW-1:0] WriteData,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [DW-1:0] Instr,
  output logic [DW-1:0] MemData,
  output logic          Stall,
  output logic          Done,
  output logic          Err
);

  import mips_pkg::*;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  mau_state_t state_q, state_d;

  logic          req_q,   req_d;
  logic          we_q,    we_d;
  logic [DW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          irw_q,   irw_d;
  logic          done_q,  done_d;
  logic          err_q,   err_d;
  logic [DW-1:0] ir_q,    ir_d;
  logic [DW-1:0] mdr_q,   mdr_d;

  logic [DW-1:0] sel_addr_s;
  logic          aligned_s;
  logic          start_s;
  logic          launch_s;
  logic          in_bus_s;
  logic          tc_s;
  logic          timer_en_s;

  assign sel_addr_s = lorD ? ALUOut : PC;
  assign aligned_s  = is_word_aligned(sel_addr_s[1:0]);
  assign start_s    = (state_q == IDLE) & Access;
  assign launch_s   = start_s & aligned_s;
  assign in_bus_s   = (state_q == BUS);
  // Count only wait states; an acked cycle ends the transaction anyway
  assign timer_en_s = in_bus_s & ~mem_ack;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wait_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (launch_s),
    .load     (1'b0),
    .load_val ({CW{1'b0}}),
    .en       (timer_en_s),
    .tc       (tc_s)
  );

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ack wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch_s) begin
          state_d = BUS;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (mem_ack || tc_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM output logic: request registers and the Done/Err pulses
  always_comb begin
    req_d   = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    irw_d   = irw_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          // Request fields are latched even for a misaligned address,
          // but only an aligned one raises the bus request.
          addr_d  = sel_addr_s;
          we_d    = MemWrite;
          wdata_d = WriteData;
          irw_d   = IRWrite;
          req_d   = aligned_s;
          err_d   = ~aligned_s;
        end else begin
          req_d = 1'b0;
        end
      end
      BUS: begin
        if (mem_ack) begin
          done_d = 1'b1;
        end else if (tc_s) begin
          err_d = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  // Capture read data into IR or MDR on an acked load
  always_comb begin
    ir_d  = ir_q;
    mdr_d = mdr_q;
    if (in_bus_s && mem_ack && !we_q) begin
      if (irw_q) begin
        ir_d = mem_rdata;
      end else begin
        mdr_d = mem_rdata;
      end
    end else begin
      ir_d  = ir_q;
      mdr_d = mdr_q;
    end
  end

  // Output and data registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= {DW{1'b0}};
      wdata_q <= {DW{1'b0}};
      irw_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ir_q    <= {DW{1'b0}};
      mdr_q   <= {DW{1'b0}};
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      irw_q   <= irw_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign Instr     = ir_q;
  assign MemData   = mdr_q;
  assign Done      = done_q;
  assign Err       = err_q;
  // Combinational so the controller freezes in the cycle it requests
  assign Stall     = in_bus_s | launch_s;

endmodule : mem_access_unit
